// File: rtl/din_debounce_edge.sv
// din_debounce_edge
//   Conditions a raw, possibly asynchronous and bouncy 1-bit input for the data
//   flop downstream. The input passes through a synchronizer chain and then a
//   debounce qualifier. The block drives a clean registered level (dout), one-cycle
//   rise/fall pulses, and a busy flag while a candidate level is being qualified.
//   Optional feature: define DIN_EDGE_COUNT_EN to build the accepted-edge counter.
//   When the macro is undefined, edge_cnt is tied to 0.
module din_debounce_edge #(
   parameter int SYNC_STAGES     = 2,   // >= 2
   parameter int DEBOUNCE_CYCLES = 4,   // >= 1
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   output logic             dout,
   output logic             rise,
   output logic             fall,
   output logic             busy,
   output logic [CNT_W-1:0] edge_cnt
);

   localparam int            QW    = $clog2(DEBOUNCE_CYCLES + 1);
   // The last count value before a new level is accepted.
   localparam logic [QW-1:0] QLAST = QW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [QW-1:0]          cnt_q, cnt_d;
   logic                   dout_q, dout_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;
   logic                   s;

   // Synchronizer shift: din enters at bit 0, s is taken from the last stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Qualifier: count consecutive cycles where s disagrees with dout, and accept
   // the new level on the DEBOUNCE_CYCLES-th one. Any agreement restarts the count.
   always_comb begin
      cnt_d  = '0;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != dout_q) begin
         if (cnt_q == QLAST) begin
            dout_d = s;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt_q + QW'(1);
         end
      end
      // Busy mirrors the registered count. It never rises with one-cycle qualify.
      busy_d = (cnt_d != '0);
   end

   // State registers; reset clears everything including the sync chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         dout_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         busy_q <= busy_d;
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

`ifdef DIN_EDGE_COUNT_EN
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

   // Count accepted edges.
   // The counter updates on the same edge that raises rise or fall, and it wraps naturally.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      if (rise_d | fall_d) begin
         edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
   end

   // Edge counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_cnt_q <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign edge_cnt = edge_cnt_q;
`else
   assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_din_debounce_edge.sv
// Bench for din_debounce_edge (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=2).
// Expected output word per cycle is {dout, rise, fall, busy}. The edge_cnt value comes
// from a small model that counts expected pulses. That count is forced to 0 when
// DIN_EDGE_COUNT_EN is undefined.
module tb_din_debounce_edge;

`ifdef DIN_EDGE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       din;
   logic       dout, rise, fall, busy;
   logic [1:0] edge_cnt;

   din_debounce_edge #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .din     (din),
      .dout    (dout),
      .rise    (rise),
      .fall    (fall),
      .busy    (busy),
      .edge_cnt(edge_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       din;
      logic       rst;
      logic [3:0] exp;   // {dout, rise, fall, busy}
      string      name;
   } vec_t;

   vec_t       tbl[$];
   int         checks   = 0;
   int         failures = 0;
   logic [1:0] model_cnt = 2'd0;

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one cycle, then sample 1 ns after the edge and compare the full output word.
   task automatic cyc(input logic d, input logic r, input logic [3:0] e, input string n);
      logic [1:0] exp_ec;
      din   = d;
      reset = r;
      @(posedge clk);
      #1;
      if (r)              model_cnt = 2'd0;
      else if (e[2] | e[1]) model_cnt = model_cnt + 2'd1;
      exp_ec = CNT_EN ? model_cnt : 2'd0;
      checks++;
      if ({dout, rise, fall, busy, edge_cnt} !== {e, exp_ec}) begin
         failures++;
         $display("FAIL %s: dout/rise/fall/busy=%b%b%b%b edge_cnt=%0d, expected %b edge_cnt=%0d",
                  n, dout, rise, fall, busy, edge_cnt, e, exp_ec);
      end
   endtask

   task automatic add(input logic d, input logic r, input logic [3:0] e, input string n);
      vec_t v;
      v.din  = d;
      v.rst  = r;
      v.exp  = e;
      v.name = n;
      tbl.push_back(v);
   endtask

   // Held step to level lvl from the opposite dout level.
   // Busy is high on edges 3-5, and dout changes with a pulse on edge 6.
   task automatic add_step(input logic lvl, input string n);
      logic [3:0] x;
      for (int e = 1; e <= 7; e++) begin
         x[3] = (e >= 6) ? lvl : ~lvl;
         x[2] = (e == 6) & lvl;
         x[1] = (e == 6) & ~lvl;
         x[0] = (e >= 3) && (e <= 5);
         add(lvl, 1'b0, x, $sformatf("%s_e%0d", n, e));
      end
   endtask

   task automatic run_table();
      foreach (tbl[i]) cyc(tbl[i].din, tbl[i].rst, tbl[i].exp, tbl[i].name);
      tbl.delete();
   endtask

   initial begin
      int rises, falls, rise_at;
      din   = 1'b1;
      reset = 1'b1;

      // Reset with din high, release, step to 0, back to 1, and back to 0.
      add(1'b1, 1'b1, 4'b0000, "reset_1");
      add(1'b1, 1'b1, 4'b0000, "reset_2");
      add_step(1'b1, "rst_release");
      add_step(1'b0, "fall_a");
      add_step(1'b1, "rise_a");
      add_step(1'b0, "fall_b");
      // Glitch: din high for 3 cycles only, then dout stays 0 and busy pulses.
      add(1'b1, 1'b0, 4'b0000, "glitch_e1");
      add(1'b1, 1'b0, 4'b0000, "glitch_e2");
      add(1'b1, 1'b0, 4'b0001, "glitch_e3");
      add(1'b0, 1'b0, 4'b0001, "glitch_e4");
      add(1'b0, 1'b0, 4'b0001, "glitch_e5");
      add(1'b0, 1'b0, 4'b0000, "glitch_e6");
      add(1'b0, 1'b0, 4'b0000, "glitch_e7");
      add(1'b0, 1'b0, 4'b0000, "glitch_e8");
      run_table();

      // Bounce: 10 cycles of toggling, then din holds 1. Index 10 is the final 0->1.
      rises   = 0;
      falls   = 0;
      rise_at = -1;
      for (int i = 0; i < 18; i++) begin
         din   = (i >= 10) || (i % 2 == 0);
         reset = 1'b0;
         @(posedge clk);
         #1;
         if (rise === 1'b1) begin
            rises++;
            rise_at = i;
         end
         if (fall === 1'b1) falls++;
      end
      model_cnt = model_cnt + 2'd1;
      check_val("bounce_rise_count", rises, 1);
      check_val("bounce_fall_count", falls, 0);
      check_val("bounce_rise_index", rise_at, 15);
      check_val("bounce_dout", int'(dout), 1);
      check_val("bounce_edge_cnt", int'(edge_cnt), CNT_EN ? int'(model_cnt) : 0);

      // Reset mid-qualify: fall back to 0, start qualifying a 1, and reset at cnt=2.
      add_step(1'b0, "pre_fall");
      add(1'b1, 1'b0, 4'b0000, "midq_e1");
      add(1'b1, 1'b0, 4'b0000, "midq_e2");
      add(1'b1, 1'b0, 4'b0001, "midq_e3");
      add(1'b1, 1'b0, 4'b0001, "midq_e4");
      add(1'b1, 1'b1, 4'b0000, "midq_reset");
      // The discarded count means the rise needs the full latency again.
      add_step(1'b1, "post_reset");
      run_table();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
